// File: rtl/cdb_broadcaster_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cdb_broadcaster_if                                                |
// | Brief  : Result-port and Common Data Bus signal bundle for cdb_broadcaster |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface cdb_broadcaster_if #(
  parameter int NUM_SRC = 3,
  parameter int LABEL_W = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*LABEL_W-1:0] src_label;
  logic [NUM_SRC*DATA_W-1:0]  src_data;
  logic [NUM_SRC-1:0]         src_full;
  logic                       BCEN;
  logic [LABEL_W-1:0]         BClabel;
  logic [DATA_W-1:0]          BCdata;
  logic                       err_drop;

  modport master (
    output src_valid, src_label, src_data,
    input  src_full, BCEN, BClabel, BCdata, err_drop
  );

  modport slave (
    input  src_valid, src_label, src_data,
    output src_full, BCEN, BClabel, BCdata, err_drop
  );
endinterface
`default_nettype wire

// File: rtl/cdb_broadcaster.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cdb_broadcaster                                                   |
// | Brief  : Per-unit result FIFOs with round-robin drive of the CDB broadcast |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module cdb_broadcaster #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 2,
  parameter int LABEL_W = 4,
  parameter int DATA_W  = 32
) (
  input wire              clk,
  input wire              nRST,
  cdb_broadcaster_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = $clog2(NUM_SRC);

  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic [PTR_W-1:0]   wr_q  [NUM_SRC];
  logic [PTR_W-1:0]   wr_d  [NUM_SRC];
  logic [PTR_W-1:0]   rd_q  [NUM_SRC];
  logic [PTR_W-1:0]   rd_d  [NUM_SRC];
  logic [LABEL_W-1:0] lbl_q [NUM_SRC][DEPTH];
  logic [LABEL_W-1:0] lbl_d [NUM_SRC][DEPTH];
  logic [DATA_W-1:0]  dat_q [NUM_SRC][DEPTH];
  logic [DATA_W-1:0]  dat_d [NUM_SRC][DEPTH];

  logic [RR_W-1:0]    rr_q, rr_d;
  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] full, push, drop, pop;
  logic               gnt_vld;
  logic [RR_W-1:0]    gnt;
  logic [RR_W:0]      scan;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [LABEL_W-1:0] lbl_in;
      assign lbl_in  = bus.src_label[i*LABEL_W +: LABEL_W];
      // full comes from the registered count only, so a same-edge pop never frees a slot
      assign full[i] = (cnt_q[i] == CNT_W'(DEPTH));
      assign push[i] = bus.src_valid[i] & ~full[i] & (lbl_in != '0);
      assign drop[i] = bus.src_valid[i] & (full[i] | (lbl_in == '0));
      assign pop[i]  = gnt_vld & (gnt == RR_W'(i));
    end
  endgenerate

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    scan    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = {1'b0, rr_q} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(NUM_SRC)) scan = scan - (RR_W+1)'(NUM_SRC);
      if (!gnt_vld && (cnt_q[scan[RR_W-1:0]] != '0)) begin
        gnt_vld = 1'b1;
        gnt     = scan[RR_W-1:0];
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    lbl_d     = lbl_q;
    dat_d     = dat_q;
    rr_d      = rr_q;
    bcen_d    = 1'b0;
    bclabel_d = '0;
    bcdata_d  = bcdata_q;
    err_d     = err_q;

    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        lbl_d[i][wr_q[i]] = bus.src_label[i*LABEL_W +: LABEL_W];
        dat_d[i][wr_q[i]] = bus.src_data[i*DATA_W +: DATA_W];
        wr_d[i]           = ptr_inc(wr_q[i]);
      end
      if (pop[i]) rd_d[i] = ptr_inc(rd_q[i]);
      if (drop[i]) err_d = 1'b1;
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end

    if (gnt_vld) begin
      bcen_d    = 1'b1;
      bclabel_d = lbl_q[gnt][rd_q[gnt]];
      bcdata_d  = dat_q[gnt][rd_q[gnt]];
      rr_d      = (gnt == RR_W'(NUM_SRC - 1)) ? '0 : gnt + RR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          lbl_q[i][j] <= '0;
          dat_q[i][j] <= '0;
        end
      end
      rr_q      <= '0;
      bcen_q    <= 1'b0;
      bclabel_q <= '0;
      bcdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lbl_q     <= lbl_d;
      dat_q     <= dat_d;
      rr_q      <= rr_d;
      bcen_q    <= bcen_d;
      bclabel_q <= bclabel_d;
      bcdata_q  <= bcdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.src_full = full;
  assign bus.BCEN     = bcen_q;
  assign bus.BClabel  = bclabel_q;
  assign bus.BCdata   = bcdata_q;
  assign bus.err_drop = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_cdb_broadcaster                                                |
// | Brief  : Vector table, corner sequences and queue-model random checks      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cdb_broadcaster;
  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int LW    = 4;
  localparam int DW    = 32;

  logic clk  = 1'b0;
  logic nRST = 1'b0;

  cdb_broadcaster_if #(.NUM_SRC(N), .LABEL_W(LW), .DATA_W(DW)) bus ();

  cdb_broadcaster #(.NUM_SRC(N), .DEPTH(DEPTH), .LABEL_W(LW), .DATA_W(DW)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [LW-1:0] label;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [N-1:0]    v;
    logic [N*LW-1:0] l;
    logic [N*DW-1:0] d;
    logic            eb;
    logic [LW-1:0]   el;
    logic [DW-1:0]   ed;
    logic [N-1:0]    ef;
    logic            ee;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one queue per unit, round-robin pointer as an integer
  ent_t          mq[N][$];
  int            m_rr;
  logic          m_bcen;
  logic [LW-1:0] m_label;
  logic [DW-1:0] m_data;
  logic          m_err;

  function automatic logic [DW-1:0] mk(input int u, input int l);
    return DW'(32'hA500_0000 + u * 256 + l);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0; m_bcen = 1'b0; m_label = '0; m_data = '0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic [N*LW-1:0] l,
                            input logic [N*DW-1:0] d);
    int   g;
    bit   was_full[N];
    ent_t e;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) was_full[i] = (mq[i].size() == DEPTH);
    if (g >= 0) begin
      e = mq[g].pop_front();
      m_bcen = 1'b1; m_label = e.label; m_data = e.data; m_rr = (g + 1) % N;
    end else begin
      m_bcen = 1'b0; m_label = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        e.label = l[i*LW +: LW];
        e.data  = d[i*DW +: DW];
        if (was_full[i] || e.label == '0) m_err = 1'b1;
        else mq[i].push_back(e);
      end
    end
  endtask

  function automatic logic [N-1:0] model_full();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = (mq[i].size() == DEPTH);
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic [LW-1:0] el,
                         input logic [DW-1:0] ed, input logic [N-1:0] ef, input logic ee);
    chk({tag, ".BCEN"},     64'(bus.BCEN),     64'(eb));
    chk({tag, ".BClabel"},  64'(bus.BClabel),  64'(el));
    chk({tag, ".BCdata"},   64'(bus.BCdata),   64'(ed));
    chk({tag, ".src_full"}, 64'(bus.src_full), 64'(ef));
    chk({tag, ".err_drop"}, 64'(bus.err_drop), 64'(ee));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_bcen, m_label, m_data, model_full(), m_err);
  endtask

  // Inputs are driven just after a falling edge; outputs are read at the next falling edge
  task automatic tick(input logic [N-1:0] v, input logic [N*LW-1:0] l, input logic [N*DW-1:0] d);
    bus.src_valid = v; bus.src_label = l; bus.src_data = d;
    @(posedge clk);
    model_edge(v, l, d);
    @(negedge clk);
  endtask

  task automatic idle();
    tick('0, '0, '0);
  endtask

  task automatic do_reset();
    bus.src_valid = '0;
    nRST = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic [N-1:0] v, input int l0, input int l1, input int l2,
                     input logic eb, input int el, input logic [DW-1:0] ed,
                     input logic [N-1:0] ef, input logic ee);
    vec_t r;
    r.v  = v;
    r.l  = {LW'(l2), LW'(l1), LW'(l0)};
    r.d  = {mk(2, l2), mk(1, l1), mk(0, l0)};
    r.eb = eb; r.el = LW'(el); r.ed = ed; r.ef = ef; r.ee = ee;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t;
    logic [N-1:0]    rv;
    logic [N*LW-1:0] rl;
    logic [N*DW-1:0] rd;

    model_reset();
    bus.src_valid = '1;
    bus.src_label = '1;
    bus.src_data  = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, '0, '0, '0, 1'b0);
    bus.src_valid = '0;
    nRST = 1'b1;

    // contention from rr=0, then single result, then overflow with units 1,2 saturating
    add(3'b111, 1, 2, 3,   1'b0, 0,  '0,          3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b1, 1,  mk(0, 1),    3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b1, 2,  mk(1, 2),    3'b000, 1'b0);
    add(3'b101, 4, 0, 6,   1'b1, 3,  mk(2, 3),    3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b1, 4,  mk(0, 4),    3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b1, 6,  mk(2, 6),    3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b0, 0,  mk(2, 6),    3'b000, 1'b0);
    add(3'b010, 0, 5, 0,   1'b0, 0,  mk(2, 6),    3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b1, 5,  32'hDEADBEEF, 3'b000, 1'b0);
    add(3'b000, 0, 0, 0,   1'b0, 0,  32'hDEADBEEF, 3'b000, 1'b0);
    add(3'b111, 7, 10, 13, 1'b0, 0,  32'hDEADBEEF, 3'b000, 1'b0);
    add(3'b111, 8, 11, 14, 1'b1, 13, mk(2, 13),   3'b011, 1'b0);
    add(3'b101, 9, 0, 15,  1'b1, 7,  mk(0, 7),    3'b110, 1'b1);
    add(3'b000, 0, 0, 0,   1'b1, 10, mk(1, 10),   3'b100, 1'b1);
    add(3'b000, 0, 0, 0,   1'b1, 14, mk(2, 14),   3'b000, 1'b1);
    add(3'b000, 0, 0, 0,   1'b1, 8,  mk(0, 8),    3'b000, 1'b1);
    add(3'b000, 0, 0, 0,   1'b1, 11, mk(1, 11),   3'b000, 1'b1);
    add(3'b000, 0, 0, 0,   1'b1, 15, mk(2, 15),   3'b000, 1'b1);
    add(3'b000, 0, 0, 0,   1'b0, 0,  mk(2, 15),   3'b000, 1'b1);
    t = tbl[7];
    t.d[DW +: DW] = 32'hDEADBEEF;
    tbl[7] = t;

    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].l, tbl[i].d);
      chk_all($sformatf("row%0d", i), tbl[i].eb, tbl[i].el, tbl[i].ed, tbl[i].ef, tbl[i].ee);
    end

    // label 0 is discarded and must not occupy a FIFO slot
    do_reset();
    tick(3'b100, {4'd0, 4'd0, 4'd0}, {mk(2, 0), 64'd0});
    chk_all("lbl0_a", 1'b0, '0, '0, 3'b000, 1'b1);
    tick(3'b100, {4'd3, 4'd0, 4'd0}, {mk(2, 3), 64'd0});
    chk_all("lbl0_b", 1'b0, '0, '0, 3'b000, 1'b1);
    idle();
    chk_all("lbl0_c", 1'b1, 4'd3, mk(2, 3), 3'b000, 1'b1);
    idle();
    chk_all("lbl0_d", 1'b0, '0, mk(2, 3), 3'b000, 1'b1);

    // asynchronous reset between edges while results are pending
    do_reset();
    tick(3'b111, {4'd3, 4'd2, 4'd1}, {mk(2, 3), mk(1, 2), mk(0, 1)});
    chk_all("ar_load", 1'b0, '0, '0, 3'b000, 1'b0);
    idle();
    chk_all("ar_first", 1'b1, 4'd1, mk(0, 1), 3'b000, 1'b0);
    #1 nRST = 1'b0;
    #1 chk_all("ar_async", 1'b0, '0, '0, 3'b000, 1'b0);
    #1 nRST = 1'b1;
    model_reset();
    idle();
    chk_all("ar_idle0", 1'b0, '0, '0, 3'b000, 1'b0);
    idle();
    chk_all("ar_idle1", 1'b0, '0, '0, 3'b000, 1'b0);
    tick(3'b010, {4'd0, 4'd9, 4'd0}, {32'd0, mk(1, 9), 32'd0});
    chk_all("ar_push", 1'b0, '0, '0, 3'b000, 1'b0);
    idle();
    chk_all("ar_bcast", 1'b1, 4'd9, mk(1, 9), 3'b000, 1'b0);
    idle();
    chk_all("ar_after", 1'b0, '0, mk(1, 9), 3'b000, 1'b0);

    // random: well-behaved sources first, then unrestricted (drops allowed)
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 3) != 0);
        rl[i*LW +: LW] = LW'($urandom_range(1, 15));
        rd[i*DW +: DW] = $urandom;
        if (c < 350) begin
          if (mq[i].size() == DEPTH) rv[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          rl[i*LW +: LW] = '0;
        end
      end
      tick(rv, rl, rd);
      chk_model($sformatf("rand%0d", c));
    end
    for (int c = 0; c < 8; c++) begin
      idle();
      chk_model($sformatf("drain%0d", c));
    end
    chk("drain_bcen", 64'(bus.BCEN), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
